// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes, opcodes,
// ALUop and datapath mux-select encodings.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        StIf  = 4'd0,
        StId  = 4'd1,
        StMa  = 4'd2,
        StMrd = 4'd3,
        StMwb = 4'd4,
        StMwr = 4'd5,
        StExr = 4'd6,
        StRwb = 4'd7,
        StBr  = 4'd8,
        StJmp = 4'd9,
        StExi = 4'd10,
        StIwb = 4'd11,
        StJal = 4'd12,
        StErr = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FUN = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Dispatch from ID on the freshly loaded opcode.
    function automatic state_t id_next(input logic [5:0] op, input bit bne_en);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = StMa;
            OP_R:         nxt = StExr;
            OP_BEQ:       nxt = StBr;
            OP_BNE:       nxt = bne_en ? StBr : StErr;
            OP_J:         nxt = StJmp;
            OP_JAL:       nxt = StJal;
            OP_ADDI:      nxt = StExi;
            default:      nxt = StErr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, mux selects
// and write strobes out.
interface mc_ctrl_fsm_if;

    logic [5:0] OP;
    logic [5:0] Fun;
    logic       zero;
    logic       MIO_ready;

    logic [3:0] state;
    logic [1:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       PC_en;
    logic       CPU_MIO;
    logic       err;

    modport master (
        input  OP, Fun, zero, MIO_ready,
        output state, ALUop, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource, IorD,
               MemRead, MemWrite, IRWrite, RegWrite, PC_en, CPU_MIO, err
    );

    modport slave (
        output OP, Fun, zero, MIO_ready,
        input  state, ALUop, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource, IorD,
               MemRead, MemWrite, IRWrite, RegWrite, PC_en, CPU_MIO, err
    );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing IF/ID/EX/MEM/WB over a shared
// datapath, stalling memory states on MIO_ready.
import mc_ctrl_fsm_pkg::*;

module mc_ctrl_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit BNE_EN      = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    state_t state_q;
    logic   ready;
    logic   is_bne;
    logic   pc_write;
    logic   pc_write_cond;

    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       err_pulse;

    // Fun is resolved by the ALU function decoder downstream, not here.
    logic unused_fun;
    assign unused_fun = ^bus.Fun;

    assign ready  = MEM_WAIT_EN ? bus.MIO_ready : 1'b1;
    assign is_bne = (bus.OP == OP_BNE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIf;
        end else begin
            case (state_q)
                StIf:    if (ready) state_q <= StId;
                StId:    state_q <= id_next(bus.OP, BNE_EN);
                StMa:    state_q <= (bus.OP == OP_SW) ? StMwr : StMrd;
                StMrd:   if (ready) state_q <= StMwb;
                StMwr:   if (ready) state_q <= StIf;
                StExr:   state_q <= StRwb;
                StExi:   state_q <= StIwb;
                default: state_q <= StIf;
            endcase
        end
    end

    always_comb begin
        alu_op        = ALUOP_ADD;
        src_a         = SRCA_PC;
        src_b         = SRCB_REG;
        reg_dst       = DST_RT;
        mem_to_reg    = WB_ALU;
        pc_source     = PC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        err_pulse     = 1'b0;
        case (state_q)
            StIf: begin
                mem_read = 1'b1;
                src_b    = SRCB_FOUR;
                ir_write = ready;
                pc_write = ready;
            end
            StId: src_b = SRCB_IMM_SH;
            StMa: begin
                src_a = SRCA_REG;
                src_b = SRCB_IMM;
            end
            StMrd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMwb: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
            end
            StMwr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StExr: begin
                src_a  = SRCA_REG;
                alu_op = ALUOP_FUN;
            end
            StRwb: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
            end
            StBr: begin
                src_a         = SRCA_REG;
                alu_op        = ALUOP_SUB;
                pc_source     = PC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            StJmp: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
            StExi: begin
                src_a = SRCA_REG;
                src_b = SRCB_IMM;
            end
            StIwb: reg_write = 1'b1;
            StJal: begin
                pc_write   = 1'b1;
                pc_source  = PC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = WB_PC;
            end
            default: err_pulse = 1'b1;
        endcase
    end

    assign bus.state    = state_q;
    assign bus.ALUop    = alu_op;
    assign bus.ALUSrcA  = src_a;
    assign bus.ALUSrcB  = src_b;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.PCSource = pc_source;
    assign bus.IorD     = i_or_d;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.IRWrite  = ir_write;
    assign bus.RegWrite = reg_write;
    assign bus.PC_en    = pc_write | (pc_write_cond & (bus.zero ^ is_bne));
    assign bus.CPU_MIO  = mem_read | mem_write;
    assign bus.err      = err_pulse;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit for the MSOC CPU.
- Sequences the shared datapath (PC, IR, register file, single ALU, unified memory port) through IF/ID/EX/MEM/WB steps per instruction.
- Drives the 2-bit ALUop consumed by the ALU function decoder; that decoder resolves funct bits into the ALU control code.
- Stalls on memory handshake MIO_ready; flags unsupported opcodes.

Parameters:
- MEM_WAIT_EN, 1, 1 = IF/MRD/MWR wait for MIO_ready; 0 = treat MIO_ready as constant 1.
- BNE_EN, 1, 1 = opcode 000101 decodes as bne; 0 = it goes to ERR.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- OP  in  6  IR[31:26], stable from the cycle after IF completes
- Fun  in  6  IR[5:0] (unused except for ERR on R-type with Fun=000000 and OP=000000 and IR nonzero — not checked; pass-through only)
- zero  in  1  ALU zero flag
- MIO_ready  in  1  memory access complete this cycle
- state  out  4  current state code (debug)
- ALUop  out  2  00 add, 01 sub, 10 funct-decoded
- ALUSrcA  out  1  0 PC, 1 reg A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- RegDst  out  2  00 rt, 01 rd, 10 r31
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  out  1  0 PC address, 1 ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register file write
- PC_en  out  1  PC load = PCWrite | (PCWriteCond & (zero ^ is_bne))
- CPU_MIO  out  1  = MemRead | MemWrite
- err  out  1  one-cycle pulse on illegal opcode

Behaviour:
- Moore FSM. State is registered; all outputs are combinational decode of the state only. Exceptions: PC_en and IRWrite are also gated by MIO_ready/zero as stated below.
- Reset: state=IF (0). Decode of IF is visible immediately. Any state aborts to IF on rst; no partial memory write persists beyond the current cycle.
- Outputs default to 0 in every state unless listed below.
- IF(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite and PCWrite assert only while MIO_ready=1.
  - Stay in IF while MIO_ready=0; go to ID when MIO_ready=1.
- ID(1): ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut). Next state by OP:
  - 100011/101011 -> MA
  - 000000 -> EXR
  - 000100/000101 -> BR
  - 000010 -> JMP
  - 000011 -> JAL
  - 001000 -> EXI
  - else -> ERR
- MA(2): ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MRD; sw -> MWR.
- MRD(3): MemRead, IorD=1. Hold until MIO_ready, then -> MWB.
- MWB(4): RegWrite, RegDst=00, MemtoReg=01 -> IF.
- MWR(5): MemWrite, IorD=1. Hold until MIO_ready, then -> IF.
- EXR(6): ALUSrcA=1, ALUSrcB=00, ALUop=10 -> RWB.
- RWB(7): RegWrite, RegDst=01, MemtoReg=00 -> IF.
- BR(8): ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01, PCWriteCond=1; is_bne=(OP==000101) -> IF.
- JMP(9): PCWrite, PCSource=10 -> IF.
- EXI(10): ALUSrcA=1, ALUSrcB=10, ALUop=00 -> IWB.
- IWB(11): RegWrite, RegDst=00, MemtoReg=00 -> IF.
- JAL(12): PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=10. PC written as link is the already-incremented PC+4. -> IF.
- ERR(13): err=1, no writes -> IF. The instruction is skipped; PC was already advanced in IF.
- Codes 14–15: unreachable; decode as ERR outputs and return to IF.
- Cycle counts (MIO_ready=1 throughout): lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, jal 3.
- MEM_WAIT_EN=0: IF/MRD/MWR each take exactly 1 cycle regardless of MIO_ready.

Decomposition:
- Shared package/header mc_defs: state codes, opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI), ALUop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUN=10), mux-select constants.
- No sub-module. Next-state logic and output decode are two always blocks in one file.

Test Plan:
- rst=1 two cycles, then release with MIO_ready=1 -> state=0; MemRead=1, IRWrite=1, PC_en=1 in the first cycle; state=1 next cycle.
- OP=100011 (lw), MIO_ready low 3 cycles in MRD -> states 0,1,2,3,3,3,3,4,0; MemRead=1, IorD=1 during all MRD cycles; single RegWrite with MemtoReg=01 in state 4.
- OP=000100 (beq), zero=1 then repeat with zero=0 -> PC_en=1 in BR only for zero=1. OP=000101 (bne) gives the inverse.
- OP=000000 -> EXR shows ALUop=10, ALUSrcB=00; RWB shows RegDst=01, RegWrite=1; 4 cycles total.
- OP=000011 (jal) -> JAL shows PC_en=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1; back to IF. OP=111111 -> ERR with err=1 for one cycle, no RegWrite/MemWrite, then IF.
- rst asserted mid-MWR while MIO_ready=0 -> next cycle state=0, MemWrite=0.
